// File: rtl/vga_sync_receiver.sv
// Sink end of a VGA timing link: locks to incoming hsync/vsync, regenerates
// pixel coordinates and a frame strobe, and flags line/frame timing faults.
module vga_sync_receiver #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned SYNC_POL    = 0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       active,
  output logic       frame_start,
  output logic       locked,
  output logic       err_line,
  output logic       err_frame,
  output logic [7:0] err_count
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_START   = H_SYNC + H_BP;
  localparam int unsigned V_START   = V_SYNC + V_BP;
  localparam int unsigned H_TIMEOUT = H_TOTAL + H_SYNC;
  localparam logic        POL       = 1'(SYNC_POL);
  localparam logic [10:0] H_MAX     = 11'h7FF;
  localparam logic [9:0]  V_MAX     = 10'h3FF;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t      state, state_nx;
  logic [3:0]  good, good_nx;
  logic        hs_s1, hs_s2, vs_s1, vs_s2;
  logic [10:0] h_cnt, h_next;
  logic [9:0]  v_cnt, v_next;
  logic        h_armed, v_armed;
  logic        h_lead, h_trail, v_lead, v_trail;
  logic        chk_en, line_bad, frame_bad, err_any, err_seen;
  logic        lock_nx, h_vis, v_vis, vis;

  // Edge detection and the counter values this cycle will load.
  always_comb begin
    h_lead  = (hs_s1 == POL) && (hs_s2 != POL);
    h_trail = (hs_s1 != POL) && (hs_s2 == POL);
    v_lead  = (vs_s1 == POL) && (vs_s2 != POL);
    v_trail = (vs_s1 != POL) && (vs_s2 == POL);
    h_next  = h_cnt;
    v_next  = v_cnt;
    if (h_lead)              h_next = 11'd0;
    else if (h_cnt != H_MAX) h_next = h_cnt + 11'd1;
    if (v_lead)                       v_next = 10'd0;
    else if (h_lead && v_cnt != V_MAX) v_next = v_cnt + 10'd1;
  end

  // Leading edges are judged on the count they end; trailing edges and the
  // timeout on the count the edge lands on.
  always_comb begin
    chk_en    = (state != SEARCH);
    line_bad  = chk_en && h_armed &&
                ((h_lead  && (h_cnt  != 11'(H_TOTAL - 1))) ||
                 (h_trail && (h_next != 11'(H_SYNC)))      ||
                 (!h_lead && (h_next == 11'(H_TIMEOUT))));
    frame_bad = chk_en && v_armed &&
                ((v_lead  && (v_cnt  != 10'(V_TOTAL - 1))) ||
                 (v_trail && (v_next != 10'(V_SYNC))));
    err_any   = line_bad || frame_bad;
    err_seen  = err_line || err_frame;
  end

  // Lock state machine; reacts to error pulses one cycle after they appear.
  always_comb begin
    state_nx = state;
    good_nx  = good;
    case (state)
      SEARCH: begin
        good_nx = 4'd0;
        if (v_lead) state_nx = VERIFY;
      end
      VERIFY: begin
        if (err_seen) begin
          state_nx = SEARCH;
          good_nx  = 4'd0;
        end else if (v_lead && !err_any) begin
          if (good == 4'(LOCK_FRAMES - 1)) begin
            state_nx = LOCKED;
            good_nx  = 4'd0;
          end else begin
            good_nx = good + 4'd1;
          end
        end
      end
      LOCKED: begin
        if (err_seen) state_nx = SEARCH;
      end
      default: begin
        state_nx = SEARCH;
        good_nx  = 4'd0;
      end
    endcase
  end

  always_comb begin
    lock_nx = (state_nx == LOCKED);
    h_vis   = (h_next >= 11'(H_START)) && (h_next < 11'(H_START + H_ACTIVE));
    v_vis   = (v_next >= 10'(V_START)) && (v_next < 10'(V_START + V_ACTIVE));
    vis     = lock_nx && h_vis && v_vis;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_s1       <= ~POL;
      hs_s2       <= ~POL;
      vs_s1       <= ~POL;
      vs_s2       <= ~POL;
      h_cnt       <= 11'd0;
      v_cnt       <= 10'd0;
      state       <= SEARCH;
      good        <= 4'd0;
      h_armed     <= 1'b0;
      v_armed     <= 1'b0;
      x_pos       <= 10'd0;
      y_pos       <= 10'd0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_line    <= 1'b0;
      err_frame   <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      hs_s1 <= hsync_in;
      hs_s2 <= hs_s1;
      vs_s1 <= vsync_in;
      vs_s2 <= vs_s1;
      h_cnt <= h_next;
      v_cnt <= v_next;
      state <= state_nx;
      good  <= good_nx;
      // Arming restarts whenever the lock is lost.
      if (state != SEARCH && state_nx == SEARCH) begin
        h_armed <= 1'b0;
        v_armed <= 1'b0;
      end else begin
        if (h_lead) h_armed <= 1'b1;
        if (v_lead) v_armed <= 1'b1;
      end
      x_pos       <= vis ? 10'(h_next - 11'(H_START)) : 10'd0;
      y_pos       <= vis ? (v_next - 10'(V_START)) : 10'd0;
      active      <= vis;
      frame_start <= lock_nx && v_lead;
      locked      <= lock_nx;
      err_line    <= line_bad;
      err_frame   <= frame_bad;
      if (err_any && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule
